// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the single shared memory port: serialises instruction fetch and
// load/store onto a fixed-latency memory. Define MEM_ARB_ROUND_ROBIN_EN for alternating priority.
module mem_port_arbiter #(
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       rdata,
    output logic              if_done,
    output logic              ls_done,
    output logic              ls_err,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp, StErr} state_e;

    localparam logic [2:0] LatCnt = 3'(READ_LAT);

    state_e     state_q;
    logic [2:0] cnt_q;
    logic       owner_ls_q;
    logic       store_q;
    logic       prio_ls;
    logic       grant_ls;
    logic       grant_if;
    logic       misaligned;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic prio_ls_q;
    assign prio_ls = prio_ls_q;
`else
    assign prio_ls = 1'b1;
`endif

    // A lone requester always wins; the priority bit only breaks ties.
    always_comb begin
        grant_ls   = ls_req && (!if_req || prio_ls);
        grant_if   = if_req && !grant_ls;
        misaligned = (ls_addr[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            owner_ls_q <= 1'b0;
            store_q    <= 1'b0;
            mem_addr   <= '0;
            mem_wr     <= 1'b0;
            mem_wdata  <= 32'd0;
            rdata      <= 32'd0;
            if_done    <= 1'b0;
            ls_done    <= 1'b0;
            ls_err     <= 1'b0;
            busy       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prio_ls_q  <= 1'b1;
`endif
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            ls_err  <= 1'b0;
            mem_wr  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_ls) begin
                        owner_ls_q <= 1'b1;
                        busy       <= 1'b1;
                        if (misaligned) begin
                            state_q <= StErr;
                        end else begin
                            state_q   <= StBusy;
                            mem_addr  <= ls_addr;
                            mem_wdata <= ls_wdata;
                            mem_wr    <= ls_we;
                            store_q   <= ls_we;
                            cnt_q     <= ls_we ? 3'd1 : LatCnt;
                        end
                    end else if (grant_if) begin
                        owner_ls_q <= 1'b0;
                        busy       <= 1'b1;
                        state_q    <= StBusy;
                        mem_addr   <= if_addr;
                        store_q    <= 1'b0;
                        cnt_q      <= LatCnt;
                    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (grant_ls) begin
                        prio_ls_q <= 1'b0;
                    end else if (grant_if) begin
                        prio_ls_q <= 1'b1;
                    end
`endif
                end
                StBusy: begin
                    if (cnt_q == 3'd1) begin
                        if (!store_q) begin
                            rdata <= mem_rdata;
                        end
                        if_done <= !owner_ls_q;
                        ls_done <= owner_ls_q;
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StResp: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                // Misaligned access: no memory cycle, error reported through the RESP slot.
                StErr: begin
                    ls_done <= 1'b1;
                    ls_err  <= 1'b1;
                    state_q <= StResp;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a fixed-latency memory model.
module tb_mem_port_arbiter;

    parameter int unsigned READ_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] rdata;
    logic        if_done;
    logic        ls_done;
    logic        ls_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .READ_LAT(READ_LAT),
        .ADDR_W  (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .mem_rdata(mem_rdata),
        .mem_addr (mem_addr),
        .mem_wr   (mem_wr),
        .mem_wdata(mem_wdata),
        .rdata    (rdata),
        .if_done  (if_done),
        .ls_done  (ls_done),
        .ls_err   (ls_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Memory model: data for an address appears READ_LAT cycles after the address does.
    logic [31:0] mem [0:255];
    logic [31:0] addr_pipe [0:7];
    logic [31:0] rd_addr;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    end

    always @(posedge clk) begin
        addr_pipe[0] <= mem_addr;
        for (int i = 1; i < 8; i++) addr_pipe[i] <= addr_pipe[i-1];
    end

    if (READ_LAT <= 1) begin : g_lat1
        assign rd_addr = mem_addr;
    end else begin : g_latn
        assign rd_addr = addr_pipe[READ_LAT-2];
    end

    assign mem_rdata = mem[rd_addr[9:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access from a single requester; req is dropped on its done pulse.
    task automatic access(input string tag, input logic is_ls, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input int exp_cyc,
                          input logic exp_err, input int exp_wr);
        int          t      = -1;
        int          wr_cnt = 0;
        logic [31:0] rd     = 32'hFFFF_FFFF;
        logic        err    = 1'b0;
        logic        own_ls = 1'b0;
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (mem_wr) wr_cnt++;
            if (if_done || ls_done) begin
                t = c; rd = rdata; err = ls_err; own_ls = ls_done;
                break;
            end
        end
        ls_req = 1'b0;
        if_req = 1'b0;
        check({tag, "_cyc"}, t, exp_cyc);
        check({tag, "_owner"}, 32'(own_ls), 32'(is_ls));
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_wrcnt"}, wr_cnt, exp_wr);
        tick();
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat = int'(READ_LAT);
        int t_ls1;
        int t_ls2;
        int t_if;
        logic [31:0] rd_if;

        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        mem[16] = 32'h2402_0005;
        reset = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_addr = '0; ls_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_dones", {29'd0, if_done, ls_done, ls_err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reset = 1'b1;
        tick();

        // Single fetch with per-cycle checks; if_addr changes mid-access must be ignored.
        if_req = 1'b1; if_addr = 32'h40;
        for (int c = 1; c <= lat; c++) begin
            tick();
            check("f_addr", mem_addr, 32'h40);
            check("f_busy", 32'(busy), 32'd1);
            check("f_early_done", 32'(if_done), 32'd0);
            if_addr = 32'h80;
        end
        tick();
        check("f_done", 32'(if_done), 32'd1);
        check("f_rdata", rdata, 32'h2402_0005);
        if_req = 1'b0;
        tick();
        check("f_busy_low", 32'(busy), 32'd0);
        check("f_done_pulse", 32'(if_done), 32'd0);
        check("f_addr_hold", mem_addr, 32'h40);

        access("st", 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h2402_0005, 2, 1'b0, 1);
        access("ld", 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, lat + 1, 1'b0, 0);
        access("mis_ld", 1'b1, 1'b0, 32'h102, 32'h0, 32'hDEAD_BEEF, 2, 1'b1, 0);
        access("mis_st", 1'b1, 1'b1, 32'h102, 32'h0BAD_F00D, 32'hDEAD_BEEF, 2, 1'b1, 0);
        access("ld2", 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, lat + 1, 1'b0, 0);
        access("f80", 1'b0, 1'b0, 32'h80, 32'h0, 32'hA5A5_0020, lat + 1, 1'b0, 0);

        // Asynchronous reset in the middle of a store.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h300; ls_wdata = 32'h55;
        tick();
        check("rst_pre_wr", 32'(mem_wr), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_wr", 32'(mem_wr), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_dones", {30'd0, if_done, ls_done}, 32'd0);
        check("arst_addr", mem_addr, 32'd0);
        ls_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);
        access("post_rst_f", 1'b0, 1'b0, 32'h40, 32'h0, 32'h2402_0005, lat + 1, 1'b0, 0);

        // Collision A: LS drops on done, IF follows in the next IDLE.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h1111_2222;
        if_req = 1'b1; if_addr = 32'h40;
        t_ls1 = -1; t_if = -1; rd_if = 32'hFFFF_FFFF;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (ls_done && t_ls1 < 0) begin t_ls1 = c; ls_req = 1'b0; end
            if (if_done && t_if < 0) begin t_if = c; if_req = 1'b0; rd_if = rdata; end
            if (t_ls1 > 0 && t_if > 0) break;
        end
        ls_req = 1'b0; if_req = 1'b0;
        check("colA_ls", t_ls1, 2);
        check("colA_gap", t_if - t_ls1, lat + 2);
        check("colA_rdata", rd_if, 32'h2402_0005);
        tick();

        // Collision B: LS re-requests right after its first done while IF is still pending.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h204; ls_wdata = 32'h33;
        if_req = 1'b1; if_addr = 32'h80;
        t_ls1 = -1; t_ls2 = -1; t_if = -1; rd_if = 32'hFFFF_FFFF;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (t_ls1 > 0 && c == t_ls1 + 1) begin
                ls_req = 1'b1; ls_addr = 32'h208; ls_wdata = 32'h44;
            end
            if (ls_done) begin
                if (t_ls1 < 0) t_ls1 = c;
                else if (t_ls2 < 0) t_ls2 = c;
                ls_req = 1'b0;
            end
            if (if_done && t_if < 0) begin t_if = c; if_req = 1'b0; rd_if = rdata; end
            if (t_ls2 > 0 && t_if > 0) break;
        end
        ls_req = 1'b0; if_req = 1'b0;
        check("colB_ls1", t_ls1, 2);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check("colB_if", t_if, 4 + lat);
        check("colB_ls2", t_ls2, 7 + lat);
`else
        check("colB_ls2", t_ls2, 5);
        check("colB_if", t_if, 7 + lat);
`endif
        check("colB_rdata", rd_if, 32'hA5A5_0020);
        tick();

        access("ld300", 1'b1, 1'b0, 32'h300, 32'h0, 32'hA5A5_00C0, lat + 1, 1'b0, 0);
        access("ld200", 1'b1, 1'b0, 32'h200, 32'h0, 32'h1111_2222, lat + 1, 1'b0, 0);
        access("ld208", 1'b1, 1'b0, 32'h208, 32'h0, 32'h44, lat + 1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequencer and arbiter for the CPU's single shared memory port.
- Serialises two requesters onto one memory with fixed read latency: instruction fetch (IF) and data load/store (LS).
- Sits between the main control unit (which raises if_req / ls_req) and the memory.
- Owns all mem_addr / mem_wr / mem_wdata timing and returns captured read data with a one-cycle done pulse per requester.

Parameters:
- READ_LAT, 2, memory read latency in cycles from address-valid to mem_rdata-valid; legal range 1..7.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  ADDR_W  fetch address.
- ls_req  in  1  load/store request; held high until ls_done.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  data address.
- ls_wdata  in  32  store data.
- mem_rdata  in  32  memory read data.
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wr  out  1  memory write strobe (registered).
- mem_wdata  out  32  memory write data (registered).
- rdata  out  32  captured read data, valid while the done pulse is high and held until the next capture.
- if_done  out  1  one-cycle fetch completion pulse.
- ls_done  out  1  one-cycle load/store completion pulse.
- ls_err  out  1  one-cycle misaligned-access pulse, coincident with ls_done.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE immediately.
  - All outputs go to 0, mem_wr included. Any in-flight access is abandoned with no done pulse.
  - Priority pointer resets to LS.
- States:
  - IDLE: samples requests at the clock edge. No request: stay. Winner: latch owner/addr/we/wdata, go to BUSY with counter = READ_LAT (load) or 1 (store).
  - Misaligned LS (ls_addr[1:0] != 0): go to ERR instead of BUSY. No memory access occurs; mem_wr stays 0.
  - BUSY: mem_addr/mem_wdata driven from latched values.
    - Store: mem_wr = 1 for exactly the single BUSY cycle.
    - Counter decrements each cycle; when it reaches 1, capture mem_rdata into rdata (loads and fetches only) and go to RESP.
  - RESP: assert the owner's done for one cycle, then return to IDLE. mem_wr = 0.
  - ERR: assert ls_done and ls_err for one cycle, then return to IDLE.
- Latency:
  - Load/fetch: request sampled at edge 0; BUSY cycles 1..READ_LAT; done and rdata valid in cycle READ_LAT+1.
  - Store: done in cycle 2.
  - Minimum spacing between grants: 3 cycles (IDLE, BUSY, RESP), because IDLE always occupies one cycle.
- Arbitration: when both requests are high in IDLE, LS wins (fixed priority; see Optional Feature). The loser stays pending; no request is dropped while its req stays high.
- Latched-value stability: requester inputs changing during BUSY have no effect on the latched values.
- Dropped request: req deasserted before grant means the request is ignored. req held high during RESP is not double-granted, because the requester drops req on done.
- rdata is unchanged on stores and on ERR.
- mem_addr holds its last value in IDLE, with no glitching to 0 except at reset.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, the winner alternates. The 1-bit pointer flips to the non-winning port after every grant. A single requester is always served regardless of the pointer.
- Undefined: fixed priority, LS always beats IF. The pointer logic is absent.

Test Plan:
- Single fetch, READ_LAT=2, if_addr=0x0000_0040, memory word 0x2402_0005 → mem_addr=0x40 in cycles 1–2, if_done and rdata=0x2402_0005 in cycle 3, busy low in cycle 4.
- Store ls_we=1, ls_addr=0x100, ls_wdata=0xDEAD_BEEF → mem_wr=1 for exactly one cycle (cycle 1), ls_done in cycle 2, and a later load of 0x100 returns 0xDEAD_BEEF.
- if_req and ls_req raised in the same cycle (fixed priority) → LS served first, IF granted in the following IDLE, if_done exactly 4 cycles after ls_done with READ_LAT=2. With MEM_ARB_ROUND_ROBIN_EN, a second collision serves IF first.
- Misaligned ls_addr=0x102 (load and store) → ls_err=ls_done=1 in cycle 2, mem_wr never asserted, rdata unchanged.
- reset driven low mid-BUSY of a store (cycle 1) → mem_wr, busy and all done outputs go to 0 asynchronously, before the next edge. After release, the FSM is in IDLE and a new fetch completes normally.
- READ_LAT=1 and READ_LAT=7 builds → load done exactly READ_LAT+1 cycles after grant, with rdata equal to the memory model's word.
